// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: MSB-first, busy framing and a done pulse.
// Define PARITY_EN to append an even-parity bit after the LSB of every frame.
module serial_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`else
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(WIDTH - 2);
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             out_q,   out_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             last_cycle;
    logic             accept;
`ifdef PARITY_EN
    logic             parity_q, parity_d;
`endif

    // The last frame cycle is the only SHIFT/PARITY cycle that can take a new word.
`ifdef PARITY_EN
    assign last_cycle = (state_q == S_PARITY);
`else
    assign last_cycle = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
`endif

    assign ready  = (state_q == S_IDLE) || last_cycle;
    assign accept = valid && ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        out_d   = IDLE_LEVEL;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif
        if (accept) begin
            state_d = S_SHIFT;
            shift_d = data;
            cnt_d   = '0;
            out_d   = data[WIDTH-1];
            busy_d  = 1'b1;
`ifdef PARITY_EN
            parity_d = ^data;
`endif
        end else if ((state_q == S_SHIFT) && (cnt_q != CNT_LAST)) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            out_d   = shift_d[WIDTH-1];
            busy_d  = 1'b1;
`ifndef PARITY_EN
            done_d  = (cnt_q == CNT_PRE);
`endif
`ifdef PARITY_EN
        end else if (state_q == S_SHIFT) begin
            state_d = S_PARITY;
            out_d   = parity_q;
            busy_d  = 1'b1;
            done_d  = 1'b1;
`endif
        end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            out_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx (WIDTH=8, IDLE_LEVEL=0): directed per-cycle
// vectors for framing/handshake, hand sequences for async reset and parity.
module tb_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       o;
        logic       b;
        logic       dn;
        logic       r;
    } vec_t;

    vec_t tbl[$];

    serial_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, check this cycle's outputs, then advance to 1ns past the next edge.
    task automatic run_cycle(input string name, input logic v, input logic [7:0] d,
                             input logic o, input logic b, input logic dn, input logic r);
        valid = v;
        data  = d;
        check({name, ".out"},   {7'd0, out},   {7'd0, o});
        check({name, ".busy"},  {7'd0, busy},  {7'd0, b});
        check({name, ".done"},  {7'd0, done},  {7'd0, dn});
        check({name, ".ready"}, {7'd0, ready}, {7'd0, r});
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [7:0] d,
                       input logic o, input logic b, input logic dn, input logic r);
        tbl.push_back('{v: v, d: d, o: o, b: b, dn: dn, r: r});
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;

        // Idle after reset, then a single A5 frame.
        add(0, 8'h00, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1);
        add(1, 8'hA5, 0, 0, 0, 1);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 1);
        // Back-to-back A5 then 3C with valid held: no gap bit.
        add(1, 8'hA5, 0, 0, 0, 1);
        add(1, 8'h3C, 1, 1, 0, 0);
        add(1, 8'h3C, 0, 1, 0, 0);
        add(1, 8'h3C, 1, 1, 0, 0);
        add(1, 8'h3C, 0, 1, 0, 0);
        add(1, 8'h3C, 0, 1, 0, 0);
        add(1, 8'h3C, 1, 1, 0, 0);
        add(1, 8'h3C, 0, 1, 0, 0);
        add(1, 8'h3C, 1, 1, 1, 1);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 1);
        // C3 frame with a stray valid pulse on bit 3 that must be ignored.
        add(1, 8'hC3, 0, 0, 0, 1);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(1, 8'hFF, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0);
        add(0, 8'h00, 1, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1);

        #13;
        check("reset.out",   {7'd0, out},   8'd0);
        check("reset.busy",  {7'd0, busy},  8'd0);
        check("reset.done",  {7'd0, done},  8'd0);
        check("reset.ready", {7'd0, ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef PARITY_EN
        foreach (tbl[i]) begin
            run_cycle($sformatf("vec%0d", i), tbl[i].v, tbl[i].d,
                      tbl[i].o, tbl[i].b, tbl[i].dn, tbl[i].r);
        end

        // Async reset during bit 3 of FF, then a clean 81 frame.
        run_cycle("abort.acc", 1, 8'hFF, 0, 0, 0, 1);
        run_cycle("abort.b0",  0, 8'h00, 1, 1, 0, 0);
        run_cycle("abort.b1",  0, 8'h00, 1, 1, 0, 0);
        run_cycle("abort.b2",  0, 8'h00, 1, 1, 0, 0);
        check("abort.b3.out", {7'd0, out}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.async.out",   {7'd0, out},   8'd0);
        check("abort.async.busy",  {7'd0, busy},  8'd0);
        check("abort.async.done",  {7'd0, done},  8'd0);
        check("abort.async.ready", {7'd0, ready}, 8'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_cycle("post.idle", 0, 8'h00, 0, 0, 0, 1);
        run_cycle("post.acc",  1, 8'h81, 0, 0, 0, 1);
        run_cycle("post.b0",   0, 8'h00, 1, 1, 0, 0);
        run_cycle("post.b1",   0, 8'h00, 0, 1, 0, 0);
        run_cycle("post.b2",   0, 8'h00, 0, 1, 0, 0);
        run_cycle("post.b3",   0, 8'h00, 0, 1, 0, 0);
        run_cycle("post.b4",   0, 8'h00, 0, 1, 0, 0);
        run_cycle("post.b5",   0, 8'h00, 0, 1, 0, 0);
        run_cycle("post.b6",   0, 8'h00, 0, 1, 0, 0);
        run_cycle("post.b7",   0, 8'h00, 1, 1, 1, 1);
        run_cycle("post.end",  0, 8'h00, 0, 0, 0, 1);
`else
        // 07 then 03 back-to-back; parity bits 1 and 0, done on the 9th bit.
        run_cycle("par.acc07", 1, 8'h07, 0, 0, 0, 1);
        run_cycle("par.a0",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.a1",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.a2",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.a3",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.a4",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.a5",    1, 8'h03, 1, 1, 0, 0);
        run_cycle("par.a6",    1, 8'h03, 1, 1, 0, 0);
        run_cycle("par.a7",    1, 8'h03, 1, 1, 0, 0);
        run_cycle("par.ap",    1, 8'h03, 1, 1, 1, 1);
        run_cycle("par.b0",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.b1",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.b2",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.b3",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.b4",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.b5",    0, 8'h00, 0, 1, 0, 0);
        run_cycle("par.b6",    0, 8'h00, 1, 1, 0, 0);
        run_cycle("par.b7",    0, 8'h00, 1, 1, 0, 0);
        run_cycle("par.bp",    0, 8'h00, 0, 1, 1, 1);
        run_cycle("par.end",   0, 8'h00, 0, 0, 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
